// File: rtl/cbus_sram_responder.sv
// rtl/cbus_sram_responder.sv - CBus responder serving single/burst accesses from an on-chip SRAM array
package cbus_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       busy
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     beat_q, beat_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic           incr_q, incr_d;
  logic           wr_q, wr_d;

  logic [63:0]    mem [MEM_WORDS];

  // Word index is taken relative to the base; upper bits alias modulo the array size.
  logic [63:0]    offset;
  logic           unused_bits;
  assign offset      = req.addr - BASE_ADDR;
  assign unused_bits = ^{req.size, offset[63:AW+3], offset[2:0]};

  // Transaction state register; reset returns to IDLE and drops any latched transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      incr_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      incr_q  <= incr_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state: accept in IDLE, count down latency in WAIT, step beats in BEAT; valid low aborts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    incr_d  = incr_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (req.valid) begin
          idx_d  = offset[AW+2:3];
          len_d  = req.len;
          incr_d = (req.burst == BURST_INCR);
          wr_d   = req.is_write;
          beat_d = '0;
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            lat_d   = LAT_INIT;
          end else begin
            state_d = S_BEAT;
          end
        end
      end
      S_WAIT: begin
        if (!req.valid) begin
          state_d = S_IDLE;
        end else if (lat_q == '0) begin
          state_d = S_BEAT;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_BEAT: begin
        if (!req.valid || (beat_q == len_q)) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 8'd1;
          if (incr_q) begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response is driven only in an unaborted beat; reads come straight from the registered index.
  always_comb begin
    resp = '0;
    busy = (state_q != S_IDLE);
    if ((state_q == S_BEAT) && req.valid) begin
      resp.ready = 1'b1;
      resp.last  = (beat_q == len_q);
      if (!wr_q) begin
        resp.data = mem[idx_q];
      end
    end
  end

  // Byte-strobed write at the edge closing each live write beat; contents are never reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_BEAT) && req.valid && wr_q) begin
      for (int b = 0; b < 8; b++) begin
        if (req.strobe[b]) begin
          mem[idx_q][8*b +: 8] <= req.data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb/tb_cbus_sram_responder.sv - scoreboard bench for cbus_sram_responder at LATENCY 2 and 0
module tb_cbus_sram_responder;
  import cbus_pkg::*;

  localparam int          MW   = 16;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        last;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int LAT = (g == 0) ? 2 : 0;

    cbus_req_t   req;
    cbus_resp_t  resp;
    logic        busy;
    logic        rst;
    logic        done_g = 1'b0;

    cbus_sram_responder #(
      .MEM_WORDS(MW),
      .LATENCY  (LAT),
      .BASE_ADDR(BASE)
    ) u_dut (
      .clk  (clk),
      .reset(rst),
      .req  (req),
      .resp (resp),
      .busy (busy)
    );

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] mdl  [MW];
    logic [63:0] wdat [16];
    logic [7:0]  wstb [16];

    // Monitor: every ready beat must match the next scoreboard entry; otherwise resp is all zero.
    always @(negedge clk) begin
      if (resp.ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("i%0d_unexpected_beat", g), 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("i%0d_beat_cycle", g), 64'(cyc), 64'(mon_e.cyc));
          check($sformatf("i%0d_beat_data", g), resp.data, mon_e.data);
          check($sformatf("i%0d_beat_last", g), 64'(resp.last), 64'(mon_e.last));
        end
      end else begin
        check($sformatf("i%0d_idle_data", g), resp.data, 64'd0);
        check($sformatf("i%0d_idle_last", g), 64'(resp.last), 64'd0);
      end
    end

    function automatic int widx(input logic [63:0] addr);
      return int'(((addr - BASE) >> 3) % MW);
    endfunction

    // One transaction from the initiator's side; the model decides every beat's cycle and data.
    task automatic txn(input logic wr, input logic [63:0] addr, input int len, input logic incr,
                       input int abort_at, input int reset_at);
      int   a;
      int   ix;
      exp_t e;
      req.valid    = 1'b1;
      req.is_write = wr;
      req.size     = 3'd3;
      req.addr     = addr;
      req.len      = 8'(len);
      req.burst    = incr ? BURST_INCR : BURST_FIXED;
      req.strobe   = wstb[0];
      req.data     = wdat[0];
      a  = cyc;
      ix = widx(addr);
      repeat (LAT) begin @(posedge clk); #1; end
      for (int i = 0; i <= len; i++) begin
        @(posedge clk); #1;
        req.strobe = wstb[i];
        req.data   = wdat[i];
        if (i == abort_at) begin
          req.valid = 1'b0;
          @(posedge clk); #1;
          check($sformatf("i%0d_abort_idle", g), 64'(busy), 64'd0);
          return;
        end
        if (i == reset_at) begin
          #2;
          rst = 1'b1;
          #1;
          check($sformatf("i%0d_rst_ready", g), 64'(resp.ready), 64'd0);
          check($sformatf("i%0d_rst_data", g), resp.data, 64'd0);
          check($sformatf("i%0d_rst_busy", g), 64'(busy), 64'd0);
          req.valid = 1'b0;
          @(posedge clk); #3;
          rst = 1'b0;
          @(posedge clk); #1;
          return;
        end
        e.cyc  = a + 1 + LAT + i;
        e.last = (i == len);
        if (wr) begin
          e.data = 64'd0;
          for (int b = 0; b < 8; b++) begin
            if (wstb[i][b]) mdl[ix][8*b +: 8] = wdat[i][8*b +: 8];
          end
        end else begin
          e.data = mdl[ix];
        end
        exp_q.push_back(e);
        if (incr) ix = (ix + 1) % MW;
      end
      @(posedge clk); #1;
      check($sformatf("i%0d_end_idle", g), 64'(busy), 64'd0);
      req.valid = 1'b0;
    endtask

    initial begin
      int len;
      int ab;
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < 16; i++) begin wdat[i] = 64'(i); wstb[i] = 8'hFF; end
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("i%0d_reset_busy", g), 64'(busy), 64'd0);
      check($sformatf("i%0d_reset_ready", g), 64'(resp.ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // preload every word with its own index
      txn(1'b1, BASE, 15, 1'b1, -1, -1);

      // strobed partial write over an all-ones word, then single read
      wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
      txn(1'b1, BASE + 64'h10, 0, 1'b1, -1, -1);
      wdat[0] = 64'h1122_3344_5566_7788; wstb[0] = 8'h0F;
      txn(1'b1, BASE + 64'h10, 0, 1'b1, -1, -1);
      txn(1'b0, BASE + 64'h10, 0, 1'b1, -1, -1);
      repeat (2) @(posedge clk);
      #1;

      // INCR read wrapping from the top word back to word 0
      txn(1'b0, BASE + 64'h70, 3, 1'b1, -1, -1);

      // FIXED write of four beats into one word, then read it with both neighbours
      for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
      txn(1'b1, BASE + 64'h28, 3, 1'b0, -1, -1);
      txn(1'b0, BASE + 64'h20, 2, 1'b1, -1, -1);

      // back-to-back transactions with no idle gap
      wdat[0] = 64'hDEAD_BEEF_0000_0001; wstb[0] = 8'hFF;
      txn(1'b0, BASE, 1, 1'b1, -1, -1);
      txn(1'b1, BASE + 64'h40, 0, 1'b1, -1, -1);
      txn(1'b0, BASE + 64'h40, 0, 1'b1, -1, -1);

      // abort after two beats of an eight-beat INCR write, then read the region
      for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      txn(1'b1, BASE + 64'h40, 7, 1'b1, 2, -1);
      txn(1'b0, BASE + 64'h38, 7, 1'b1, -1, -1);

      // async reset in the middle of a write burst, then read back
      for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      txn(1'b1, BASE + 64'h50, 5, 1'b1, -1, 3);
      txn(1'b0, BASE + 64'h50, 5, 1'b1, -1, -1);

      // randomized traffic, including aliased addresses and aborts
      repeat (60) begin
        for (int i = 0; i < 16; i++) begin
          wdat[i] = {$urandom, $urandom};
          wstb[i] = 8'($urandom);
        end
        len = int'($urandom_range(0, 7));
        ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        txn(1'($urandom), BASE + 64'($urandom_range(0, 63)) * 64'd8 + 64'($urandom_range(0, 7)),
            len, 1'($urandom), ab, -1);
      end

      repeat (4) @(posedge clk);
      #1;
      check($sformatf("i%0d_queue_drained", g), 64'(exp_q.size()), 64'd0);
      done_g = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(gen_inst[0].done_g && gen_inst[1].done_g) && (t < 50000)) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d cycles want completion before 50000", t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
